half_adder: RTL and testbench

- Single-bit half adder, bit-sliced across a WIDTH-wide lane vector.
- Produces Sum = A xor B and CarryOut = A and B per lane.
- Leaf arithmetic cell for adder trees and incrementers.
- Optional output register stage, selected by parameter, for use in pipelined datapaths.

---
 rtl/half_adder.sv | 65 ++++++
 tb/tb_half_adder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//   WIDTH independent single-bit half-adder lanes with an optional output
//   register stage. Each lane computes Sum = A ^ B and CarryOut = A & B, so
//   {CarryOut[i], Sum[i]} = A[i] + B[i]. Lanes never exchange carries.
//
// Parameters
//   WIDTH      : number of lanes (>= 1)
//   REGISTERED : 0 -> outputs combinational from A/B, clk/rst_n unused
//                1 -> outputs registered on rising clk, 1 cycle latency
//
// Ports
//   clk      : clock, rising edge (registered mode only)
//   rst_n    : asynchronous active-low reset, clears outputs (registered only)
//   A, B     : per-lane addends
//   Sum      : per-lane sum bit
//   CarryOut : per-lane carry bit
// ---------------------------------------------------------------------------
module half_adder #(
  parameter int unsigned WIDTH      = 1,
  parameter bit          REGISTERED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] CarryOut
);

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;

  // Purely bitwise, so an X on one lane cannot reach any other lane.
  always_comb begin
    sum_d   = A ^ B;
    carry_d = A & B;
  end

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= '0;
      end else begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end

    assign Sum      = sum_q;
    assign CarryOut = carry_q;
  end else begin : g_comb
    // clk/rst_n are intentionally unused in this mode.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign Sum      = sum_d;
    assign CarryOut = carry_d;
  end

endmodule

// File: tb/tb_half_adder.sv
// ---------------------------------------------------------------------------
// tb_half_adder
//   Self-checking bench for half_adder. Several instances cover the
//   combinational and registered variants at different widths.
// ---------------------------------------------------------------------------
module tb_half_adder;

  logic clk;
  logic rst_n;

  // combinational, WIDTH=1
  logic       a1, b1, s1, c1;
  // combinational, WIDTH=8
  logic [7:0] a8, b8, s8, c8;
  // combinational, WIDTH=4
  logic [3:0] a4, b4, s4, c4;
  // registered, WIDTH=1
  logic       ar1, br1, sr1, cr1;
  // registered, WIDTH=4
  logic [3:0] ar4, br4, sr4, cr4;

  int checks   = 0;
  int failures = 0;

  half_adder #(.WIDTH(1), .REGISTERED(1'b0)) u_c1 (
    .clk(1'b0), .rst_n(1'b0), .A(a1), .B(b1), .Sum(s1), .CarryOut(c1));
  half_adder #(.WIDTH(8), .REGISTERED(1'b0)) u_c8 (
    .clk(1'b0), .rst_n(1'b0), .A(a8), .B(b8), .Sum(s8), .CarryOut(c8));
  half_adder #(.WIDTH(4), .REGISTERED(1'b0)) u_c4 (
    .clk(1'b0), .rst_n(1'b0), .A(a4), .B(b4), .Sum(s4), .CarryOut(c4));
  half_adder #(.WIDTH(1), .REGISTERED(1'b1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .A(ar1), .B(br1), .Sum(sr1), .CarryOut(cr1));
  half_adder #(.WIDTH(4), .REGISTERED(1'b1)) u_r4 (
    .clk(clk), .rst_n(rst_n), .A(ar4), .B(br4), .Sum(sr4), .CarryOut(cr4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit (actual=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         wide;   // 0: drive WIDTH=1 instance, 1: drive WIDTH=8 instance
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic [7:0] co;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Per-lane arithmetic reference: {co, sum} from the 2-bit sum of each lane.
  function automatic logic [7:0] lanes4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] s;
    logic [3:0] c;
    logic [1:0] t;
    for (int j = 0; j < 4; j++) begin
      t    = {1'b0, a[j]} + {1'b0, b[j]};
      s[j] = t[0];
      c[j] = t[1];
    end
    return {c, s};
  endfunction

  initial begin
    vecs[0] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 8'h01, 8'h01, 8'h00};
    vecs[2] = '{1'b0, 8'h01, 8'h00, 8'h01, 8'h00};
    vecs[3] = '{1'b0, 8'h01, 8'h01, 8'h00, 8'h01};
    vecs[4] = '{1'b1, 8'hF0, 8'hCC, 8'h3C, 8'hC0};
    vecs[5] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF};

    a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    ar1 = 1'b1; br1 = 1'b1; ar4 = 4'hF; br4 = 4'hF;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_r1", {14'b0, cr1, sr1}, 16'h0000);
    check("reset_r4", {8'b0, cr4, sr4}, 16'h0000);

    // Combinational table, each vector held 100 ns.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wide) begin
        a8 = vecs[i].a; b8 = vecs[i].b;
        #50;
        check($sformatf("comb8_vec%0d", i), {c8, s8}, {vecs[i].co, vecs[i].sum});
      end else begin
        a1 = vecs[i].a[0]; b1 = vecs[i].b[0];
        #50;
        check($sformatf("comb1_vec%0d", i), {14'b0, c1, s1},
              {14'b0, vecs[i].co[0], vecs[i].sum[0]});
      end
      #50;
    end

    // Many edges have passed with A=B=1 while in reset.
    check("reset_hold_r1", {14'b0, cr1, sr1}, 16'h0000);
    check("reset_hold_r4", {8'b0, cr4, sr4}, 16'h0000);

    // Latency: release synchronously, load 1,0 then 1,1.
    @(negedge clk);
    rst_n = 1'b1; ar1 = 1'b1; br1 = 1'b0;
    #4 check("lat_before_N", {14'b0, cr1, sr1}, 16'h0000);
    @(posedge clk); #1;
    check("lat_after_N", {14'b0, cr1, sr1}, 16'h0001);
    @(negedge clk);
    ar1 = 1'b1; br1 = 1'b1;
    #4 check("lat_before_N1", {14'b0, cr1, sr1}, 16'h0001);
    @(posedge clk); #1;
    check("lat_after_N1", {14'b0, cr1, sr1}, 16'h0002);

    // Asynchronous reset between edges with A=B=1.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst_r1", {14'b0, cr1, sr1}, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst_hold_r1_%0d", k), {14'b0, cr1, sr1}, 16'h0000);
    end

    // WIDTH=4 random stream, then reset mid-cycle.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 7) begin
        ar4 = 4'hF; br4 = 4'hA;
      end else begin
        ar4 = 4'($urandom_range(0, 15));
        br4 = 4'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
      check($sformatf("stream_%0d", k), {8'b0, cr4, sr4}, {8'b0, lanes4(ar4, br4)});
    end
    @(negedge clk);
    ar4 = 4'h9; br4 = 4'h3;
    #2 rst_n = 1'b0;
    #1 check("async_rst_r4", {8'b0, cr4, sr4}, 16'h0000);
    @(posedge clk); #1;
    check("rst_hold_r4", {8'b0, cr4, sr4}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1; ar4 = 4'h6; br4 = 4'h3;
    #4 check("release_before_r4", {8'b0, cr4, sr4}, 16'h0000);
    @(posedge clk); #1;
    check("release_first_r4", {8'b0, cr4, sr4}, 16'h0025);

    // Exhaustive WIDTH=4, both variants.
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      a4 = 4'(v >> 4); b4 = 4'(v);
      ar4 = 4'(v >> 4); br4 = 4'(v);
      #1 check($sformatf("exh_comb_%0d", v), {8'b0, c4, s4}, {8'b0, lanes4(a4, b4)});
      @(posedge clk); #1;
      check($sformatf("exh_reg_%0d", v), {8'b0, cr4, sr4}, {8'b0, lanes4(ar4, br4)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
